// File: rtl/score_ram_writer_pkg.sv
// hud_pkg: shared HUD constants, writer FSM states and the double-dabble step used by the BCD converter.
package hud_pkg;
   typedef enum logic [2:0] {IDLE, CONVERT, WR_SCORE, WR_LIVES, DONE} hud_wr_state_t;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam int SCORE_ADDR_DEF = 7;
   localparam int LIVES_ADDR_DEF = 32;
   // One step on {bcd[15:0], bin[13:0]}: bump nibbles >= 5 by 3, then shift left.
   function automatic logic [29:0] dd_step(input logic [29:0] v);
      logic [29:0] a;
      a = v;
      for (int k = 0; k < 4; k++)
         if (a[14+4*k +: 4] >= 4'd5) a[14+4*k +: 4] = a[14+4*k +: 4] + 4'd3;
      return {a[28:0], 1'b0};
   endfunction
endpackage

// File: rtl/score_ram_writer_if.sv
// score_ram_writer_if: refresh request inputs plus the HUD RAM write port driven by the writer.
interface score_ram_writer_if;
   logic        update;
   logic [13:0] score_in;
   logic [3:0]  lives_in;
   logic        busy;
   logic        done;
   logic        we;
   logic [7:0]  write_address;
   logic [7:0]  data_In;
   modport master (output update, score_in, lives_in, input busy, done, we, write_address, data_In);
   modport slave (input update, score_in, lives_in, output busy, done, we, write_address, data_In);
endinterface

// File: rtl/score_ram_writer_bin2bcd_seq.sv
// bin2bcd_seq: 14-bit to 4-digit BCD, one double-dabble step per cycle for 14 cycles after start.
module bin2bcd_seq
   import hud_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        done,
   output logic [15:0] bcd
);
   logic [29:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (start) begin
         acc_d = {16'd0, bin};
         cnt_d = 4'd14;
      end else if (cnt_q != 4'd0) begin
         acc_d = dd_step(acc_q);
         cnt_d = cnt_q - 4'd1;
      end
   end
   // done flags the cycle whose step is the last; bcd is that step's result.
   assign done = (cnt_q == 4'd1) && !start;
   assign bcd  = acc_d[29:14];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/score_ram_writer.sv
// score_ram_writer: converts score/lives to ASCII and writes them into the fixed HUD RAM digit slots.
module score_ram_writer
   import hud_pkg::*;
#(
   parameter int SCORE_ADDR = SCORE_ADDR_DEF,
   parameter int LIVES_ADDR = LIVES_ADDR_DEF,
   parameter int SCORE_MAX  = 9999
) (
   input logic               Clk,
   input logic               Reset_n,
   score_ram_writer_if.slave bus
);
   localparam logic [13:0] SMAX = 14'(SCORE_MAX);
   hud_wr_state_t state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  lives_q, lives_d, plives_q, plives_d, src_lives;
   logic [13:0] pscore_q, pscore_d, src_score, sat_score;
   logic        pend_q, pend_d, we_q, we_d, start, conv_done;
   logic [7:0]  addr_q, addr_d, data_q, data_d;
   logic [15:0] digits_q, digits_d, conv_bcd;
   // A request seen in DONE supersedes any queued one and starts at once.
   assign src_score = bus.update ? bus.score_in : pscore_q;
   assign src_lives = bus.update ? bus.lives_in : plives_q;
   assign sat_score = src_score > SMAX ? SMAX : src_score;
   assign start = (state_q == IDLE && bus.update) || (state_q == DONE && (bus.update || pend_q));
   bin2bcd_seq u_conv (
      .clk   (Clk),
      .rst_n (Reset_n),
      .start (start),
      .bin   (sat_score),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lives_d  = lives_q;
      pend_d   = pend_q;
      pscore_d = pscore_q;
      plives_d = plives_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      digits_d = digits_q;
      if (bus.update && !start) begin
         pend_d   = 1'b1;
         pscore_d = bus.score_in;
         plives_d = bus.lives_in;
      end
      if (start) begin
         state_d = CONVERT;
         pend_d  = 1'b0;
         lives_d = src_lives > 4'd9 ? 4'd9 : src_lives;
      end
      // Write outputs are registered, so each write is issued on the edge entering its cycle.
      unique case (state_q)
         CONVERT: if (conv_done) begin
            state_d  = WR_SCORE;
            idx_d    = 2'd0;
            digits_d = conv_bcd;
            we_d     = 1'b1;
            addr_d   = 8'(SCORE_ADDR);
            data_d   = ASCII_ZERO + {4'd0, conv_bcd[15:12]};
         end
         WR_SCORE: begin
            we_d = 1'b1;
            if (idx_q == 2'd3) begin
               state_d = WR_LIVES;
               addr_d  = 8'(LIVES_ADDR);
               data_d  = ASCII_ZERO + {4'd0, lives_q};
            end else begin
               idx_d  = idx_q + 2'd1;
               addr_d = 8'(SCORE_ADDR) + {6'd0, idx_d};
               data_d = ASCII_ZERO + {4'd0, digits_q[{~idx_d, 2'b00} +: 4]};
            end
         end
         WR_LIVES: state_d = DONE;
         default: if (!start) state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         lives_q  <= '0;
         pend_q   <= 1'b0;
         pscore_q <= '0;
         plives_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         digits_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lives_q  <= lives_d;
         pend_q   <= pend_d;
         pscore_q <= pscore_d;
         plives_q <= plives_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         digits_q <= digits_d;
      end
   end
   assign bus.busy          = state_q != IDLE;
   assign bus.done          = state_q == DONE;
   assign bus.we            = we_q;
   assign bus.write_address = addr_q;
   assign bus.data_In       = data_q;
endmodule

// File: tb/tb_score_ram_writer.sv
// tb_score_ram_writer: directed and randomized refresh scenarios checked cycle by cycle
// against an arithmetic model of the HUD writes, busy and done.
module tb_score_ram_writer;
   localparam int MAXC = 128;
   logic Clk = 1'b0;
   logic Reset_n = 1'b1;
   score_ram_writer_if bus ();
   score_ram_writer dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail = 0;
   bit upd_v[MAXC];
   int us[MAXC], ul[MAXC];
   int exp_busy[MAXC], exp_done[MAXC], exp_we[MAXC], exp_addr[MAXC], exp_data[MAXC];
   int hold_addr = 0;
   int hold_data = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dig(input int v, input int j);
      int p = 1000;
      for (int k = 0; k < j; k++) p = p / 10;
      return (v / p) % 10;
   endfunction

   task automatic clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         upd_v[c] = 1'b0;
         us[c] = int'($urandom_range(0, 16383));
         ul[c] = int'($urandom_range(0, 15));
      end
   endtask

   task automatic put_upd(input int c, input int s, input int l);
      upd_v[c] = 1'b1;
      us[c] = s;
      ul[c] = l;
   endtask

   // Refresh at edge t: busy after edges t..t+19, writes after t+14..t+18, done after t+19.
   // A request at edge <= end of the current refresh queues (last wins) and starts at that end.
   task automatic build_model(output int n, output int nref);
      int st[$], ss[$], sl[$];
      int bu, ps, pl, a, d, sat, lv;
      bit hp;
      bu = -1; ps = 0; pl = 0; hp = 1'b0; a = hold_addr; d = hold_data;
      for (int t = 0; t < MAXC; t++) begin
         exp_busy[t] = 0; exp_done[t] = 0; exp_we[t] = 0;
      end
      for (int t = 0; t < MAXC; t++) if (upd_v[t]) begin
         if (hp && bu < t) begin
            st.push_back(bu); ss.push_back(ps); sl.push_back(pl);
            bu = bu + 20; hp = 1'b0;
         end
         if (t > bu) begin
            st.push_back(t); ss.push_back(us[t]); sl.push_back(ul[t]);
            bu = t + 20;
         end else begin
            hp = 1'b1; ps = us[t]; pl = ul[t];
         end
      end
      if (hp) begin
         st.push_back(bu); ss.push_back(ps); sl.push_back(pl);
      end
      nref = st.size();
      n = 0;
      foreach (st[i]) begin
         sat = ss[i] > 9999 ? 9999 : ss[i];
         lv = sl[i] > 9 ? 9 : sl[i];
         for (int k = st[i]; k < st[i] + 20; k++) exp_busy[k] = 1;
         exp_done[st[i] + 19] = 1;
         for (int j = 0; j < 4; j++) begin
            exp_we[st[i] + 14 + j] = 1;
            exp_addr[st[i] + 14 + j] = 7 + j;
            exp_data[st[i] + 14 + j] = 48 + dig(sat, j);
         end
         exp_we[st[i] + 18] = 1;
         exp_addr[st[i] + 18] = 32;
         exp_data[st[i] + 18] = 48 + lv;
         n = st[i] + 22;
      end
      for (int t = 0; t < MAXC; t++) begin
         if (exp_we[t] != 0) begin
            a = exp_addr[t]; d = exp_data[t];
         end
         exp_addr[t] = a; exp_data[t] = d;
      end
   endtask

   task automatic run_seq(input int n, output int ndone);
      ndone = 0;
      for (int c = 0; c < n; c++) begin
         bus.update = upd_v[c];
         bus.score_in = 14'(us[c]);
         bus.lives_in = 4'(ul[c]);
         @(negedge Clk);
         ndone += int'(bus.done);
         chk($sformatf("busy@%0d", c), 32'(bus.busy), exp_busy[c]);
         chk($sformatf("done@%0d", c), 32'(bus.done), exp_done[c]);
         chk($sformatf("we@%0d", c), 32'(bus.we), exp_we[c]);
         chk($sformatf("addr@%0d", c), 32'(bus.write_address), exp_addr[c]);
         chk($sformatf("data@%0d", c), 32'(bus.data_In), exp_data[c]);
      end
      bus.update = 1'b0;
      hold_addr = exp_addr[n - 1];
      hold_data = exp_data[n - 1];
   endtask

   task automatic scenario(input string tag);
      int n, nref, nd;
      build_model(n, nref);
      run_seq(n, nd);
      chk({tag, "_done_count"}, nd, nref);
   endtask

   initial begin
      int n, nref, nd, nb, k;
      bus.update = 1'b0;
      bus.score_in = '0;
      bus.lives_in = '0;
      #1 Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_we", 32'(bus.we), 0);
      chk("rst_addr", 32'(bus.write_address), 0);
      chk("rst_data", 32'(bus.data_In), 0);
      Reset_n = 1'b1;
      @(negedge Clk);

      clear_stim(); put_upd(0, 1234, 2); scenario("s1234");
      clear_stim(); put_upd(0, 0, 0); scenario("s0");
      clear_stim(); put_upd(0, 12000, 15); scenario("sat");
      clear_stim(); put_upd(0, 9999, 9); scenario("s9999");
      clear_stim(); put_upd(0, 10000, 10); scenario("s10000");
      clear_stim(); put_upd(0, 5, 1); put_upd(3, 77, 3); put_upd(8, 450, 2); scenario("pend");
      clear_stim(); put_upd(0, 42, 4); put_upd(20, 8765, 6); scenario("done_cycle");
      clear_stim(); put_upd(0, 300, 3); put_upd(21, 16383, 1); scenario("idle_gap");

      for (int r = 0; r < 8; r++) begin
         clear_stim();
         put_upd(0, int'($urandom_range(0, 16383)), int'($urandom_range(0, 15)));
         k = int'($urandom_range(0, 3));
         for (int j = 0; j < k; j++)
            put_upd(int'($urandom_range(1, 22)), int'($urandom_range(0, 16383)), int'($urandom_range(0, 15)));
         scenario($sformatf("rand%0d", r));
      end

      clear_stim(); put_upd(0, 2468, 5);
      build_model(n, nref);
      run_seq(16, nd);
      @(posedge Clk); #1;
      chk("pre_rst_we", 32'(bus.we), exp_we[16]);
      Reset_n = 1'b0;
      #1;
      chk("midrst_we", 32'(bus.we), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_done", 32'(bus.done), 0);
      chk("midrst_addr", 32'(bus.write_address), 0);
      chk("midrst_data", 32'(bus.data_In), 0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      nd = 0; nb = 0;
      repeat (25) begin
         @(negedge Clk);
         nd += int'(bus.done);
         nb += int'(bus.busy);
      end
      chk("post_rst_no_done", nd, 0);
      chk("post_rst_idle", nb, 0);
      hold_addr = 0; hold_data = 0;
      clear_stim(); put_upd(0, int'($urandom_range(0, 16383)), int'($urandom_range(0, 15))); scenario("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/score_ram_writer.md
# score_ram_writer

Write-side controller for the HUD text RAM. Takes binary score and lives values from game logic, converts them to ASCII decimal digits with a sequential double-dabble converter, and issues single-cycle writes into the fixed score and lives digit slots of the HUD RAM. The HUD RAM's layout is fixed: "Score:" then 4 digits at 7..10, "Lives:" then 1 digit at 32. This block drives the RAM's write port (`we`, `write_address`, `data_In`) while the display reader uses the read port.

## Interface
- `SCORE_ADDR`, default 7: address of the most-significant score digit; digits occupy `SCORE_ADDR`..`SCORE_ADDR+3`.
- `LIVES_ADDR`, default 32: address of the single lives digit.
- `SCORE_MAX`, default 9999: saturation ceiling for the score.
- `Clk`  in  1  system clock; all state on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `update`  in  1  request to refresh the HUD digits; sampled every cycle.
- `score_in`  in  14  binary score (0..16383 accepted).
- `lives_in`  in  4  binary lives count.
- `busy`  out  1  high while a refresh is in progress (any state but IDLE).
- `done`  out  1  one-cycle pulse when a refresh completes.
- `we`  out  1  RAM write enable, registered.
- `write_address`  out  8  RAM write address, registered.
- `data_In`  out  8  RAM write data (ASCII), registered.

## Operation
- States: IDLE, CONVERT, WR_SCORE, WR_LIVES, DONE.
- IDLE: on `update`=1, latch `min(score_in, SCORE_MAX)` and `min(lives_in, 9)` into working registers, clear the BCD accumulator, set the bit counter to 14, and go to CONVERT.
- CONVERT: performs one double-dabble step per cycle. In each step, add 3 to every BCD nibble that is >= 5, then shift {BCD, binary} left by 1. After 14 steps, go to WR_SCORE with the digit index at 0.
- WR_SCORE: in each cycle, write `8'h30 + digit[3-i]` to `SCORE_ADDR+i` (most significant digit first), for i = 0..3. Then go to WR_LIVES.
- WR_LIVES: write `8'h30 + lives` to `LIVES_ADDR`, then go to DONE.
- DONE: assert `done` for one cycle. If `pending` is set, start a new refresh from the pending registers (same as the IDLE entry) and clear `pending`; otherwise go to IDLE.
- `update` while busy: copy `score_in`/`lives_in` into the pending registers and set `pending`. A later `update` overwrites them (last request wins). At most one refresh is ever queued.
- `update` in the DONE cycle is treated as a busy-time request: it lands in the pending registers and starts immediately.
- `we` is high only in WR_SCORE/WR_LIVES cycles. `write_address`/`data_In` hold their last values when `we`=0.
- Widths: BCD accumulator is 16 bits. Saturation happens before conversion, so every digit is 0..9.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `we`=0, `write_address`=0, `data_In`=0, `pending`=0, all working registers 0.
- With `update` sampled at edge 0: `busy`=1 from cycle 1; CONVERT spans cycles 1–14; `we`=1 in cycles 15–18 (score) and cycle 19 (lives); `done`=1 in cycle 20; `busy`=0 from cycle 21 if nothing is pending.
- Fixed latency: 20 cycles from the request edge to `done`; no write ever occurs before cycle 15.
- Back-to-back: with `pending` set, the second refresh's CONVERT begins in cycle 21 and `busy` stays high with no gap.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). The partial write sequence is abandoned and `done` is not pulsed.

## Structure
- Shared package `hud_pkg`:
  - state enum `hud_wr_state_t`
  - `ASCII_ZERO = 8'h30`
  - default `SCORE_ADDR`/`LIVES_ADDR` constants, which the RAM init and the reader also use
- Sub-module `bin2bcd_seq`: a 14-bit to 4-digit sequential double-dabble converter with start/done.
- The top level keeps the FSM, the pending queue, and the write sequencing.

## Test plan
- `score_in`=1234, `lives_in`=2, `update` pulse → writes (7,0x31), (8,0x32), (9,0x33), (10,0x34), (32,0x32) in cycles 15–19; `done` in cycle 20.
- `score_in`=0, `lives_in`=0 → four writes of 0x30 to 7..10, then 0x30 to 32.
- `score_in`=12000, `lives_in`=15 → saturated to 0x39 at 7..10 and 0x39 at 32.
- Refresh with 5/1, then two `update` pulses during busy (77/3, then 450/2) → after the first `done`, the second refresh writes 0x30,0x34,0x35,0x30 and 0x32. Exactly two `done` pulses in total, and `busy` shows no gap.
- `Reset_n` pulled low in cycle 17 → `we` is low in the same cycle, no `done`, state IDLE. A fresh `update` after release runs the full 20-cycle sequence.
